sum_group_accumulator: RTL and testbench

- Downstream consumer of the a+b sum stream. Takes the valid/ready sum output directly from the adder's output double buffer.
- Accumulates consecutive sums into groups of group_len beats, or fewer if a beat carries up_last.
- Emits one widened total per group, with its beat count, on a registered valid/ready output.
- Sits between the adder and the result sink. Provides block-level reduction without losing throughput.

---
 rtl/sum_group_accumulator.sv | 82 ++++++++
 tb/tb_sum_group_accumulator.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_group_accumulator.sv
// Sums consecutive words of the a+b stream into groups of group_len beats (or fewer on up_last)
// and presents each widened total with its beat count through a one-entry valid/ready output register.
module sum_group_accumulator #(
  parameter int width     = 8,
  parameter int group_len = 4,
  parameter int out_width = width + $clog2(group_len) + 1,
  parameter int cnt_width = $clog2(group_len + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 up_valid,
  output logic                 up_ready,
  input  logic [width-1:0]     up_data,
  input  logic                 up_last,
  output logic                 down_valid,
  input  logic                 down_ready,
  output logic [out_width-1:0] down_data,
  output logic [cnt_width-1:0] down_count
);

  // Handshake: a word moves when valid & ready are both high at a rising edge. valid never
  // waits on ready; up_ready depends only on the output register state, down_ready and rst.
  logic [out_width-1:0] acc, acc_d;
  logic [cnt_width-1:0] cnt, cnt_d;
  logic                 down_valid_d;
  logic [out_width-1:0] down_data_d;
  logic [cnt_width-1:0] down_count_d;

  logic                 up_fire;
  logic                 down_fire;
  logic                 close;
  logic [out_width-1:0] sum_next;
  logic [cnt_width-1:0] cnt_inc;

  assign up_ready  = rst & (~down_valid | down_ready);
  assign up_fire   = up_valid & up_ready;
  assign down_fire = down_valid & down_ready;
  assign sum_next  = acc + out_width'(up_data);
  assign cnt_inc   = cnt + cnt_width'(1);
  assign close     = (cnt == cnt_width'(group_len - 1)) | up_last;

  always_comb begin
    acc_d        = acc;
    cnt_d        = cnt;
    down_valid_d = down_valid;
    down_data_d  = down_data;
    down_count_d = down_count;
    if (down_fire) begin
      down_valid_d = 1'b0;
    end
    if (up_fire) begin
      if (close) begin
        // A closing beat reloads the output even when it is drained in the same cycle.
        down_data_d  = sum_next;
        down_count_d = cnt_inc;
        down_valid_d = 1'b1;
        acc_d        = '0;
        cnt_d        = '0;
      end else begin
        acc_d = sum_next;
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc        <= '0;
      cnt        <= '0;
      down_valid <= 1'b0;
      down_data  <= '0;
      down_count <= '0;
    end else begin
      acc        <= acc_d;
      cnt        <= cnt_d;
      down_valid <= down_valid_d;
      down_data  <= down_data_d;
      down_count <= down_count_d;
    end
  end

endmodule

// File: tb/tb_sum_group_accumulator.sv
// Directed and randomised checks of sum_group_accumulator (width 8, group_len 4).
module tb_sum_group_accumulator;

  localparam int W  = 8;
  localparam int G  = 4;
  localparam int OW = W + $clog2(G) + 1;
  localparam int CW = $clog2(G + 1);

  logic          clk;
  logic          rst;
  logic          up_valid;
  logic          up_ready;
  logic [W-1:0]  up_data;
  logic          up_last;
  logic          down_valid;
  logic          down_ready;
  logic [OW-1:0] down_data;
  logic [CW-1:0] down_count;

  int n_cmp;
  int n_fail;

  logic [OW-1:0] obs_d[$];
  logic [CW-1:0] obs_c[$];
  logic [OW-1:0] exp_q[$];
  logic [CW-1:0] exp_c[$];

  logic          stall_prev;
  logic [OW-1:0] prev_d;
  logic [CW-1:0] prev_c;

  sum_group_accumulator #(.width(W), .group_len(G)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_data    (up_data),
    .up_last    (up_last),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_data  (down_data),
    .down_count (down_count)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

  // Output monitor: inputs only change just after a rising edge, so what is seen on the
  // falling edge is what the next rising edge transfers.
  always @(negedge clk) begin
    if (!rst) begin
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev) begin
        n_cmp++;
        if (down_valid !== 1'b1 || down_data !== prev_d || down_count !== prev_c) begin
          n_fail++;
          $display("FAIL stall_stable: got v=%0b d=%0d c=%0d, need v=1 d=%0d c=%0d",
                   down_valid, down_data, down_count, prev_d, prev_c);
        end
      end
      if (down_valid === 1'b1 && down_ready === 1'b1) begin
        obs_d.push_back(down_data);
        obs_c.push_back(down_count);
      end
      stall_prev <= (down_valid === 1'b1) && (down_ready === 1'b0);
      prev_d     <= down_data;
      prev_c     <= down_count;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input logic l, output int waits);
    logic ok;
    ok       = 1'b0;
    waits    = 0;
    up_valid = 1'b1;
    up_data  = d;
    up_last  = l;
    while (!ok && waits < 50) begin
      @(negedge clk);
      waits++;
      ok = up_ready;
      tick();
    end
    up_valid = 1'b0;
    up_last  = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL send_timeout: word %0d not accepted within 50 cycles", d);
    end
  endtask

  task automatic clear_obs();
    obs_d.delete();
    obs_c.delete();
  endtask

  task automatic test_reset();
    rst        = 1'b0;
    up_valid   = 1'b0;
    up_data    = '0;
    up_last    = 1'b0;
    down_ready = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (down_valid !== 1'b0 || down_data !== '0 || down_count !== '0 || up_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%0b d=%0d c=%0d ur=%0b, need 0 0 0 0",
               down_valid, down_data, down_count, up_ready);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (up_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got up_ready=%0b, need 1", up_ready);
    end
  endtask

  task automatic test_basic_group();
    int w;
    clear_obs();
    down_ready = 1'b1;
    send(8'd1, 1'b0, w);
    send(8'd2, 1'b0, w);
    send(8'd3, 1'b0, w);
    n_cmp++;
    if (down_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_early_valid: got down_valid=%0b after 3 beats, need 0", down_valid);
    end
    send(8'd4, 1'b0, w);
    n_cmp++;
    if (down_valid !== 1'b1 || down_data !== 11'd10 || down_count !== 3'd4) begin
      n_fail++;
      $display("FAIL basic_total: got v=%0b d=%0d c=%0d, need v=1 d=10 c=4",
               down_valid, down_data, down_count);
    end
    tick();
    n_cmp++;
    if (down_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_one_cycle: got down_valid=%0b one cycle later, need 0", down_valid);
    end
    n_cmp++;
    if (obs_d.size() != 1) begin
      n_fail++;
      $display("FAIL basic_count_out: got %0d outputs, need 1", obs_d.size());
    end
  endtask

  task automatic test_back_to_back();
    int w;
    int slow;
    clear_obs();
    slow       = 0;
    down_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(8'd255, 1'b0, w);
      if (w != 1) slow++;
    end
    tick();
    n_cmp++;
    if (slow != 0) begin
      n_fail++;
      $display("FAIL b2b_ready: got %0d stalled beats, need 0", slow);
    end
    n_cmp++;
    if (obs_d.size() != 2) begin
      n_fail++;
      $display("FAIL b2b_outputs: got %0d outputs, need 2", obs_d.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (obs_d[i] !== 11'd1020 || obs_c[i] !== 3'd4) begin
          n_fail++;
          $display("FAIL b2b_total%0d: got d=%0d c=%0d, need d=1020 c=4", i, obs_d[i], obs_c[i]);
        end
      end
    end
  endtask

  task automatic test_last();
    int w;
    logic [OW-1:0] ed[4];
    logic [CW-1:0] ec[4];
    clear_obs();
    ed = '{11'd12, 11'd4, 11'd6, 11'd4};
    ec = '{3'd2, 3'd4, 3'd1, 3'd4};
    down_ready = 1'b1;
    send(8'd5, 1'b0, w);
    send(8'd7, 1'b1, w);
    for (int i = 0; i < 4; i++) send(8'd1, 1'b0, w);
    send(8'd6, 1'b1, w);              // last on first beat
    for (int i = 0; i < 4; i++) send(8'd1, i == 3, w);  // last on the 4th beat
    repeat (2) tick();
    n_cmp++;
    if (obs_d.size() != 4) begin
      n_fail++;
      $display("FAIL last_outputs: got %0d outputs, need 4", obs_d.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (obs_d[i] !== ed[i] || obs_c[i] !== ec[i]) begin
          n_fail++;
          $display("FAIL last_total%0d: got d=%0d c=%0d, need d=%0d c=%0d",
                   i, obs_d[i], obs_c[i], ed[i], ec[i]);
        end
      end
    end
  endtask

  task automatic test_stall();
    int w;
    clear_obs();
    down_ready = 1'b0;
    send(8'd1, 1'b0, w);
    send(8'd2, 1'b0, w);
    send(8'd3, 1'b0, w);
    send(8'd4, 1'b0, w);
    up_valid = 1'b1;
    up_data  = 8'd9;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (up_ready !== 1'b0 || down_valid !== 1'b1 || down_data !== 11'd10 || down_count !== 3'd4) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got ur=%0b v=%0b d=%0d c=%0d, need ur=0 v=1 d=10 c=4",
                 i, up_ready, down_valid, down_data, down_count);
      end
      tick();
    end
    down_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(8'd9, 1'b0, w);
    repeat (2) tick();
    n_cmp++;
    if (obs_d.size() != 2 || obs_d[0] !== 11'd10 || obs_c[0] !== 3'd4 ||
        obs_d[1] !== 11'd36 || obs_c[1] !== 3'd4) begin
      n_fail++;
      $display("FAIL stall_release: got %0d outputs first d=%0d c=%0d, need 10/4 then 36/4",
               obs_d.size(), (obs_d.size() > 0) ? obs_d[0] : '0, (obs_c.size() > 0) ? obs_c[0] : '0);
    end
  endtask

  task automatic test_async_reset();
    int w;
    clear_obs();
    down_ready = 1'b0;
    send(8'd7, 1'b1, w);
    #3;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (down_valid !== 1'b0 || down_data !== '0 || down_count !== '0 || up_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst_pending: got v=%0b d=%0d c=%0d ur=%0b, need all 0",
               down_valid, down_data, down_count, up_ready);
    end
    tick();
    rst        = 1'b1;
    down_ready = 1'b1;
    send(8'd3, 1'b0, w);
    send(8'd3, 1'b0, w);
    #3;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (down_valid !== 1'b0 || up_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst_mid: got v=%0b ur=%0b, need 0 0", down_valid, up_ready);
    end
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) send(8'd2, 1'b0, w);
    repeat (2) tick();
    n_cmp++;
    if (obs_d.size() != 1 || obs_d[0] !== 11'd8 || obs_c[0] !== 3'd4) begin
      n_fail++;
      $display("FAIL async_rst_next: got %0d outputs first d=%0d, need one output 8/4",
               obs_d.size(), (obs_d.size() > 0) ? obs_d[0] : '0);
    end
  endtask

  task automatic test_random();
    logic [W-1:0]  words[1000];
    logic          lasts[1000];
    logic [OW-1:0] acc;
    logic [CW-1:0] cnt;
    logic          ok;
    int            w;
    int            n;
    clear_obs();
    exp_q.delete();
    exp_c.delete();
    acc = '0;
    cnt = '0;
    for (int i = 0; i < 1000; i++) begin
      words[i] = W'($urandom_range(0, 255));
      lasts[i] = ($urandom_range(0, 7) == 0) || (i == 999);
      acc = acc + OW'(words[i]);
      cnt = cnt + 1'b1;
      if (cnt == CW'(G) || lasts[i]) begin
        exp_q.push_back(acc);
        exp_c.push_back(cnt);
        acc = '0;
        cnt = '0;
      end
    end
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) begin
        up_valid   = 1'b0;
        down_ready = ($urandom_range(0, 3) != 0);
        tick();
      end
      up_valid = 1'b1;
      up_data  = words[i];
      up_last  = lasts[i];
      ok = 1'b0;
      w  = 0;
      while (!ok && w < 200) begin
        down_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        ok = up_ready;
        tick();
        w++;
      end
      if (!ok) begin
        n_cmp++;
        n_fail++;
        $display("FAIL rand_timeout: word %0d not accepted", i);
      end
    end
    up_valid   = 1'b0;
    up_last    = 1'b0;
    down_ready = 1'b1;
    n = 0;
    while (obs_d.size() < exp_q.size() && n < 20) begin
      tick();
      n++;
    end
    repeat (2) tick();
    n_cmp++;
    if (obs_d.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rand_group_count: got %0d groups, need %0d", obs_d.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_d.size(); i++) begin
      n_cmp++;
      if (obs_d[i] !== exp_q[i] || obs_c[i] !== exp_c[i]) begin
        n_fail++;
        $display("FAIL rand_group%0d: got d=%0d c=%0d, need d=%0d c=%0d",
                 i, obs_d[i], obs_c[i], exp_q[i], exp_c[i]);
      end
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_fail     = 0;
    stall_prev = 1'b0;
    test_reset();
    test_basic_group();
    test_back_to_back();
    test_last();
    test_stall();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
